// File: rtl/primitive_laplacian_builder.sv
// ---------------------------------------------------------------------------
// primitive_laplacian_builder
//   Accepts a weighted undirected edge stream and accumulates the adjacency
//   matrix A and the degree vector D. It then streams the graph Laplacian
//   L = D - A in row-major order to the eigen-decomposition unit.
//   All values are signed Q8.8 two's complement. Accumulation saturates at
//   the positive maximum.
//
// Ports
//   clk, rst_n       clock (rising edge) and asynchronous active-low reset
//   start            level; sampled in IDLE to begin a build
//   edge_valid/ready valid/ready handshake for the edge stream
//   edge_u/v/w/last  edge endpoints, unsigned weight, and final-edge marker
//   mat_valid/ready  valid/ready handshake for the Laplacian stream
//   mat_row/col      coordinates of mat_data
//   mat_data         L[row][col]
//   mat_last         marks entry (N-1,N-1)
//   done             build and stream complete; held while start stays high
//   edge_count       accepted non-dropped edges (saturating)
//   self_loop_err    sticky: an edge with u==v was dropped
//   sat_err          sticky: an A or D accumulation saturated
// ---------------------------------------------------------------------------
module primitive_laplacian_builder #(
    parameter int MATRIX_SIZE = 64,
    parameter int PRECISION   = 16,
    parameter int IDX_W       = $clog2(MATRIX_SIZE)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 edge_valid,
    output logic                 edge_ready,
    input  logic [IDX_W-1:0]     edge_u,
    input  logic [IDX_W-1:0]     edge_v,
    input  logic [PRECISION-1:0] edge_w,
    input  logic                 edge_last,
    output logic                 mat_valid,
    input  logic                 mat_ready,
    output logic [IDX_W-1:0]     mat_row,
    output logic [IDX_W-1:0]     mat_col,
    output logic [PRECISION-1:0] mat_data,
    output logic                 mat_last,
    output logic                 done,
    output logic [15:0]          edge_count,
    output logic                 self_loop_err,
    output logic                 sat_err
);
    localparam int CNT_W = 2 * IDX_W;
    // N is a power of two, so the flat index of entry (N-1,N-1) is all ones.
    localparam logic [CNT_W-1:0]     LAST_IDX = {CNT_W{1'b1}};
    localparam logic [PRECISION-1:0] SAT_MAX  = {1'b0, {(PRECISION-1){1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_ACCEPT = 3'd2,
        S_EMIT   = 3'd3,
        S_DONE   = 3'd4
    } state_e;

    // The saturation flag is returned in the MSB, and the clamped sum sits below it.
    function automatic logic [PRECISION:0] sat_add(input logic [PRECISION-1:0] a,
                                                   input logic [PRECISION-1:0] b);
        logic [PRECISION:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, SAT_MAX}) begin
            return {1'b1, SAT_MAX};
        end else begin
            return {1'b0, sum[PRECISION-1:0]};
        end
    endfunction

    // A is stored flat and row-major: index = {row, col}.
    logic [PRECISION-1:0] a_mem [MATRIX_SIZE*MATRIX_SIZE];
    logic [PRECISION-1:0] d_mem [MATRIX_SIZE];

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     clr_cnt_q, clr_cnt_d;
    logic [CNT_W-1:0]     emit_idx_q, emit_idx_d;
    logic                 phase_q, phase_d;
    logic [IDX_W-1:0]     u_q, u_d, v_q, v_d;
    logic [PRECISION-1:0] w_q, w_d;
    logic                 last_q, last_d, drop_q, drop_d;
    logic [15:0]          edge_count_q, edge_count_d;
    logic                 self_loop_err_q, self_loop_err_d;
    logic                 sat_err_q, sat_err_d;
    logic                 edge_ready_q, edge_ready_d;
    logic                 mat_valid_q, mat_valid_d;
    logic [IDX_W-1:0]     mat_row_q, mat_row_d, mat_col_q, mat_col_d;
    logic [PRECISION-1:0] mat_data_q, mat_data_d;
    logic                 mat_last_q, mat_last_d;
    logic                 done_q, done_d;

    logic                 a_we_s, d_we_s;
    logic [CNT_W-1:0]     a_waddr_s;
    logic [IDX_W-1:0]     d_waddr_s;
    logic [PRECISION-1:0] a_wdata_s, d_wdata_s;
    logic [PRECISION:0]   a_sum_s, d_sum_s;
    logic [IDX_W-1:0]     emit_row_s, emit_col_s;
    logic [PRECISION-1:0] emit_data_s;

    // Laplacian entry at the current emit index: degree on the diagonal, -A elsewhere.
    assign emit_row_s  = emit_idx_q[CNT_W-1:IDX_W];
    assign emit_col_s  = emit_idx_q[IDX_W-1:0];
    assign emit_data_s = (emit_row_s == emit_col_s) ? d_mem[emit_row_s]
                                                    : ({PRECISION{1'b0}} - a_mem[emit_idx_q]);

    // Next-state, datapath and memory write-port control.
    always_comb begin
        state_d         = state_q;
        clr_cnt_d       = clr_cnt_q;
        emit_idx_d      = emit_idx_q;
        phase_d         = phase_q;
        u_d             = u_q;
        v_d             = v_q;
        w_d             = w_q;
        last_d          = last_q;
        drop_d          = drop_q;
        edge_count_d    = edge_count_q;
        self_loop_err_d = self_loop_err_q;
        sat_err_d       = sat_err_q;
        edge_ready_d    = edge_ready_q;
        mat_valid_d     = mat_valid_q;
        mat_row_d       = mat_row_q;
        mat_col_d       = mat_col_q;
        mat_data_d      = mat_data_q;
        mat_last_d      = mat_last_q;
        done_d          = done_q;
        a_we_s          = 1'b0;
        a_waddr_s       = {CNT_W{1'b0}};
        a_wdata_s       = {PRECISION{1'b0}};
        d_we_s          = 1'b0;
        d_waddr_s       = {IDX_W{1'b0}};
        d_wdata_s       = {PRECISION{1'b0}};
        a_sum_s         = {(PRECISION+1){1'b0}};
        d_sum_s         = {(PRECISION+1){1'b0}};
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d         = S_CLEAR;
                    clr_cnt_d       = {CNT_W{1'b0}};
                    edge_count_d    = 16'h0000;
                    self_loop_err_d = 1'b0;
                    sat_err_d       = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CLEAR: begin
                a_we_s    = 1'b1;
                a_waddr_s = clr_cnt_q;
                // D is cleared during the first N cycles, while the upper index bits are zero.
                if (clr_cnt_q[CNT_W-1:IDX_W] == {IDX_W{1'b0}}) begin
                    d_we_s    = 1'b1;
                    d_waddr_s = clr_cnt_q[IDX_W-1:0];
                end else begin
                    d_we_s = 1'b0;
                end
                if (clr_cnt_q == LAST_IDX) begin
                    state_d      = S_ACCEPT;
                    phase_d      = 1'b0;
                    edge_ready_d = 1'b1;
                end else begin
                    clr_cnt_d = clr_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            S_ACCEPT: begin
                if (!phase_q) begin
                    if (edge_ready_q && edge_valid) begin
                        u_d          = edge_u;
                        v_d          = edge_v;
                        w_d          = edge_w;
                        last_d       = edge_last;
                        drop_d       = (edge_u == edge_v);
                        phase_d      = 1'b1;
                        edge_ready_d = 1'b0;
                        if (edge_u == edge_v) begin
                            self_loop_err_d = 1'b1;
                        end else begin
                            a_sum_s   = sat_add(a_mem[{edge_u, edge_v}], edge_w);
                            d_sum_s   = sat_add(d_mem[edge_u], edge_w);
                            a_we_s    = 1'b1;
                            a_waddr_s = {edge_u, edge_v};
                            a_wdata_s = a_sum_s[PRECISION-1:0];
                            d_we_s    = 1'b1;
                            d_waddr_s = edge_u;
                            d_wdata_s = d_sum_s[PRECISION-1:0];
                            sat_err_d = sat_err_q | a_sum_s[PRECISION] | d_sum_s[PRECISION];
                        end
                    end else begin
                        phase_d = 1'b0;
                    end
                end else begin
                    // Second half of the edge: the mirrored entry and the other endpoint's degree.
                    phase_d = 1'b0;
                    if (!drop_q) begin
                        a_sum_s   = sat_add(a_mem[{v_q, u_q}], w_q);
                        d_sum_s   = sat_add(d_mem[v_q], w_q);
                        a_we_s    = 1'b1;
                        a_waddr_s = {v_q, u_q};
                        a_wdata_s = a_sum_s[PRECISION-1:0];
                        d_we_s    = 1'b1;
                        d_waddr_s = v_q;
                        d_wdata_s = d_sum_s[PRECISION-1:0];
                        sat_err_d = sat_err_q | a_sum_s[PRECISION] | d_sum_s[PRECISION];
                        if (edge_count_q != 16'hFFFF) begin
                            edge_count_d = edge_count_q + 16'd1;
                        end else begin
                            edge_count_d = edge_count_q;
                        end
                    end else begin
                        edge_count_d = edge_count_q;
                    end
                    if (last_q) begin
                        state_d      = S_EMIT;
                        emit_idx_d   = {CNT_W{1'b0}};
                        edge_ready_d = 1'b0;
                    end else begin
                        edge_ready_d = 1'b1;
                    end
                end
            end
            S_EMIT: begin
                // The first entry loads while mat_valid is still low (one cycle after entry).
                // Later entries load on each accepted handshake.
                if (!mat_valid_q || mat_ready) begin
                    if (mat_valid_q && mat_last_q) begin
                        mat_valid_d = 1'b0;
                        mat_last_d  = 1'b0;
                        done_d      = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        mat_valid_d = 1'b1;
                        mat_row_d   = emit_row_s;
                        mat_col_d   = emit_col_s;
                        mat_data_d  = emit_data_s;
                        mat_last_d  = (emit_idx_q == LAST_IDX);
                        emit_idx_d  = emit_idx_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    mat_valid_d = mat_valid_q;
                end
            end
            S_DONE: begin
                if (!start) begin
                    done_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    done_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers. Reset drops any build in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            clr_cnt_q       <= {CNT_W{1'b0}};
            emit_idx_q      <= {CNT_W{1'b0}};
            phase_q         <= 1'b0;
            u_q             <= {IDX_W{1'b0}};
            v_q             <= {IDX_W{1'b0}};
            w_q             <= {PRECISION{1'b0}};
            last_q          <= 1'b0;
            drop_q          <= 1'b0;
            edge_count_q    <= 16'h0000;
            self_loop_err_q <= 1'b0;
            sat_err_q       <= 1'b0;
            edge_ready_q    <= 1'b0;
            mat_valid_q     <= 1'b0;
            mat_row_q       <= {IDX_W{1'b0}};
            mat_col_q       <= {IDX_W{1'b0}};
            mat_data_q      <= {PRECISION{1'b0}};
            mat_last_q      <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            clr_cnt_q       <= clr_cnt_d;
            emit_idx_q      <= emit_idx_d;
            phase_q         <= phase_d;
            u_q             <= u_d;
            v_q             <= v_d;
            w_q             <= w_d;
            last_q          <= last_d;
            drop_q          <= drop_d;
            edge_count_q    <= edge_count_d;
            self_loop_err_q <= self_loop_err_d;
            sat_err_q       <= sat_err_d;
            edge_ready_q    <= edge_ready_d;
            mat_valid_q     <= mat_valid_d;
            mat_row_q       <= mat_row_d;
            mat_col_q       <= mat_col_d;
            mat_data_q      <= mat_data_d;
            mat_last_q      <= mat_last_d;
            done_q          <= done_d;
        end
    end

    // A/D storage. It has no reset; the CLEAR state rewrites it at the start of every build.
    always_ff @(posedge clk) begin
        if (a_we_s) begin
            a_mem[a_waddr_s] <= a_wdata_s;
        end
        if (d_we_s) begin
            d_mem[d_waddr_s] <= d_wdata_s;
        end
    end

    assign edge_ready    = edge_ready_q;
    assign mat_valid     = mat_valid_q;
    assign mat_row       = mat_row_q;
    assign mat_col       = mat_col_q;
    assign mat_data      = mat_data_q;
    assign mat_last      = mat_last_q;
    assign done          = done_q;
    assign edge_count    = edge_count_q;
    assign self_loop_err = self_loop_err_q;
    assign sat_err       = sat_err_q;

endmodule

// File: tb/tb_primitive_laplacian_builder.sv
// Self-checking bench for primitive_laplacian_builder with N=4.
// A behavioural graph model computes the expected Laplacian for each build.
// One compare process checks every presented entry against that model.
module tb_primitive_laplacian_builder;
    localparam int N  = 4;
    localparam int P  = 16;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          edge_valid = 1'b0;
    logic          edge_ready;
    logic [IW-1:0] edge_u = 2'd0;
    logic [IW-1:0] edge_v = 2'd0;
    logic [P-1:0]  edge_w = 16'h0000;
    logic          edge_last = 1'b0;
    logic          mat_valid;
    logic          mat_ready = 1'b0;
    logic [IW-1:0] mat_row;
    logic [IW-1:0] mat_col;
    logic [P-1:0]  mat_data;
    logic          mat_last;
    logic          done;
    logic [15:0]   edge_count;
    logic          self_loop_err;
    logic          sat_err;

    primitive_laplacian_builder #(.MATRIX_SIZE(N), .PRECISION(P), .IDX_W(IW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .edge_valid(edge_valid), .edge_ready(edge_ready),
        .edge_u(edge_u), .edge_v(edge_v), .edge_w(edge_w), .edge_last(edge_last),
        .mat_valid(mat_valid), .mat_ready(mat_ready),
        .mat_row(mat_row), .mat_col(mat_col), .mat_data(mat_data), .mat_last(mat_last),
        .done(done), .edge_count(edge_count),
        .self_loop_err(self_loop_err), .sat_err(sat_err)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    // Current graph and its expected results.
    int          q_u[$];
    int          q_v[$];
    int          q_w[$];
    logic [15:0] exp_data[N*N];
    int          exp_cnt;
    bit          exp_loop;
    bit          exp_sat;

    // Compare-process state.
    bit          chk_en = 1'b0;
    bit          rand_rdy = 1'b0;
    int          exp_idx = 0;
    int          hs_count = 0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_word = 32'd0;
    logic [15:0] got_mat[N*N];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic fail_msg(input string name);
        n_total++;
        $display("FAIL %s: got timeout/extra expected event", name);
    endtask

    // Behavioural model: build A and D from the edge list, then L = D - A.
    task automatic build_model();
        int a[N][N];
        int d[N];
        int s;
        for (int i = 0; i < N; i++) begin
            d[i] = 0;
            for (int j = 0; j < N; j++) a[i][j] = 0;
        end
        exp_cnt = 0; exp_loop = 1'b0; exp_sat = 1'b0;
        for (int k = 0; k < q_u.size(); k++) begin
            if (q_u[k] == q_v[k]) begin
                exp_loop = 1'b1;
            end else begin
                s = a[q_u[k]][q_v[k]] + q_w[k];
                if (s > 32767) begin s = 32767; exp_sat = 1'b1; end
                a[q_u[k]][q_v[k]] = s;
                a[q_v[k]][q_u[k]] = s;
                s = d[q_u[k]] + q_w[k];
                if (s > 32767) begin s = 32767; exp_sat = 1'b1; end
                d[q_u[k]] = s;
                s = d[q_v[k]] + q_w[k];
                if (s > 32767) begin s = 32767; exp_sat = 1'b1; end
                d[q_v[k]] = s;
                exp_cnt++;
            end
        end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                exp_data[i*N+j] = (i == j) ? 16'(d[i]) : 16'(-a[i][j]);
    endtask

    task automatic add_edge(input int u, input int v, input int w);
        q_u.push_back(u); q_v.push_back(v); q_w.push_back(w);
    endtask

    task automatic clear_edges();
        q_u.delete(); q_v.delete(); q_w.delete();
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, " edge_ready"}, 32'(edge_ready), 32'd0);
        chk({tag, " mat_valid"}, 32'(mat_valid), 32'd0);
        chk({tag, " mat_row/col"}, 32'({mat_row, mat_col}), 32'd0);
        chk({tag, " mat_data"}, 32'(mat_data), 32'd0);
        chk({tag, " mat_last"}, 32'(mat_last), 32'd0);
        chk({tag, " done"}, 32'(done), 32'd0);
        chk({tag, " edge_count"}, 32'(edge_count), 32'd0);
        chk({tag, " errors"}, 32'({self_loop_err, sat_err}), 32'd0);
    endtask

    // Drive the edge list. Optional random gaps; tput checks the 2-cycle handshake spacing.
    task automatic feed(input bit gaps, input bit tput);
        int ts[$];
        bit got;
        int n;
        for (int k = 0; k < q_u.size(); k++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    edge_valid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            edge_valid = 1'b1;
            edge_u     = IW'(q_u[k]);
            edge_v     = IW'(q_v[k]);
            edge_w     = P'(q_w[k]);
            edge_last  = (k == q_u.size() - 1);
            got = 1'b0; n = 0;
            while (!got && n < 300) begin
                @(negedge clk);
                got = edge_ready;
                @(posedge clk); #1;
                n++;
            end
            if (!got) begin
                fail_msg("edge accept");
                break;
            end
            ts.push_back(cyc);
        end
        edge_valid = 1'b0;
        edge_last  = 1'b0;
        if (tput) begin
            chk("T6 handshakes", 32'(ts.size()), 32'd8);
            for (int k = 1; k < ts.size(); k++)
                chk("T6 hs interval", 32'(ts[k] - ts[k-1]), 32'd2);
        end
    endtask

    task automatic begin_build(input bit gaps, input bit tput);
        exp_idx = 0; hs_count = 0; prev_stall = 1'b0; chk_en = 1'b1;
        start = 1'b1;
        feed(gaps, tput);
    endtask

    task automatic finish_build(input string tag);
        int n;
        n = 0;
        while (!done && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!done) fail_msg({tag, " done wait"});
        chk({tag, " handshakes"}, 32'(hs_count), 32'(N*N));
        chk({tag, " edge_count"}, 32'(edge_count), 32'(exp_cnt));
        chk({tag, " self_loop_err"}, 32'(self_loop_err), 32'(exp_loop));
        chk({tag, " sat_err"}, 32'(sat_err), 32'(exp_sat));
        chk({tag, " mat_valid after last"}, 32'(mat_valid), 32'd0);
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk({tag, " done clears"}, 32'(done), 32'd0);
    endtask

    // Cycle counter.
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Downstream ready: always high, or random per cycle.
    initial forever begin
        @(posedge clk); #1;
        mat_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Compare process. It runs on the falling edge; a valid&ready seen here handshakes on the next rise.
    initial forever begin
        @(negedge clk);
        if (rst_n && chk_en) begin
            if (prev_stall && !mat_valid) fail_msg("valid dropped while stalled");
            if (mat_valid) begin
                if (exp_idx < N*N) begin
                    chk("mat_row", 32'(mat_row), 32'(exp_idx / N));
                    chk("mat_col", 32'(mat_col), 32'(exp_idx % N));
                    chk("mat_data", 32'(mat_data), 32'(exp_data[exp_idx]));
                    chk("mat_last", 32'(mat_last), (exp_idx == N*N-1) ? 32'd1 : 32'd0);
                    got_mat[exp_idx] = mat_data;
                end else begin
                    fail_msg("extra entry");
                end
                if (prev_stall)
                    chk("hold while stalled", 32'({mat_row, mat_col, mat_data, mat_last}), prev_word);
                if (mat_ready) begin
                    hs_count++;
                    exp_idx++;
                    prev_stall = 1'b0;
                end else begin
                    prev_stall = 1'b1;
                    prev_word  = 32'({mat_row, mat_col, mat_data, mat_last});
                end
            end else begin
                prev_stall = 1'b0;
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        int n;
        int ne;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // T1 triangle path
        clear_edges();
        add_edge(0, 1, 16'h0100); add_edge(1, 2, 16'h0200); add_edge(0, 1, 16'h0080);
        build_model();
        chk("model T1 L11", 32'(exp_data[5]), 32'h0380);
        chk("model T1 L01", 32'(exp_data[1]), 32'hFE80);
        begin_build(1'b0, 1'b0);
        finish_build("T1");
        chk("T1 L00", 32'(got_mat[0]), 32'h0180);
        chk("T1 L01", 32'(got_mat[1]), 32'hFE80);
        chk("T1 L11", 32'(got_mat[5]), 32'h0380);
        chk("T1 L12", 32'(got_mat[6]), 32'hFE00);
        chk("T1 L22", 32'(got_mat[10]), 32'h0200);
        chk("T1 L33", 32'(got_mat[15]), 32'h0000);
        chk("T1 edge_count", 32'(edge_count), 32'd3);

        // T2 self-loop
        clear_edges();
        add_edge(2, 2, 16'h0100); add_edge(0, 3, 16'h0040);
        build_model();
        begin_build(1'b0, 1'b0);
        finish_build("T2");
        chk("T2 L03", 32'(got_mat[3]), 32'hFFC0);
        chk("T2 L30", 32'(got_mat[12]), 32'hFFC0);
        chk("T2 L22", 32'(got_mat[10]), 32'h0000);
        chk("T2 self_loop_err", 32'(self_loop_err), 32'd1);
        chk("T2 edge_count", 32'(edge_count), 32'd1);

        // T3 saturation
        clear_edges();
        add_edge(0, 1, 16'h7000); add_edge(0, 1, 16'h7000);
        build_model();
        begin_build(1'b0, 1'b0);
        finish_build("T3");
        chk("T3 L01", 32'(got_mat[1]), 32'h8001);
        chk("T3 L00", 32'(got_mat[0]), 32'h7FFF);
        chk("T3 sat_err", 32'(sat_err), 32'd1);

        // T4 backpressure on the T1 graph
        clear_edges();
        add_edge(0, 1, 16'h0100); add_edge(1, 2, 16'h0200); add_edge(0, 1, 16'h0080);
        build_model();
        rand_rdy = 1'b1;
        begin_build(1'b0, 1'b0);
        finish_build("T4");
        rand_rdy = 1'b0;

        // T6 throughput: 8 back-to-back edges
        clear_edges();
        for (int k = 0; k < 8; k++)
            add_edge(k % N, (k + 1) % N, 16'h0010 * (k + 1));
        build_model();
        begin_build(1'b0, 1'b1);
        finish_build("T6");

        // Randomized graphs with random gaps and random backpressure
        rand_rdy = 1'b1;
        for (int r = 0; r < 6; r++) begin
            clear_edges();
            ne = $urandom_range(1, 10);
            for (int k = 0; k < ne; k++) begin
                if ($urandom_range(0, 3) == 0)
                    add_edge($urandom_range(0, N-1), $urandom_range(0, N-1), $urandom_range(16'h4000, 16'hFFFF));
                else
                    add_edge($urandom_range(0, N-1), $urandom_range(0, N-1), $urandom_range(0, 16'h0FFF));
            end
            build_model();
            begin_build(1'b1, 1'b0);
            finish_build("RAND");
        end
        rand_rdy = 1'b0;

        // T5 reset after 5 emitted entries, then a clean T2 build
        clear_edges();
        add_edge(0, 1, 16'h0100); add_edge(1, 2, 16'h0200); add_edge(0, 1, 16'h0080);
        build_model();
        begin_build(1'b0, 1'b0);
        n = 0;
        while (hs_count < 5 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (hs_count < 5) fail_msg("T5 reach 5 entries");
        chk("T5 entries before reset", 32'(hs_count), 32'd5);
        rst_n = 1'b0;
        start = 1'b0;
        chk_en = 1'b0;
        #1;
        check_zero_outputs("T5 reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_zero_outputs("T5 after reset");
        clear_edges();
        add_edge(2, 2, 16'h0100); add_edge(0, 3, 16'h0040);
        build_model();
        begin_build(1'b0, 1'b0);
        finish_build("T5");
        chk("T5 L01 no stale", 32'(got_mat[1]), 32'h0000);
        chk("T5 L03", 32'(got_mat[3]), 32'hFFC0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
